water_level_controller: RTL
===========================

// Module: water_level_controller
// PURPOSE
//  Actuator-side counterpart of the water flow monitor. It drives the inlet valve
//  and drain pump to move the drum water level to a commanded target, then reports
//  done or fault. It sits between the wash-cycle sequencer (start/op/target) and the
//  valve/pump drivers. It exports monitor_mode and consumes flow_error from the flow monitor.
// PARAMETERS
//  LEVEL_W        10    width of level sensor and target
//  TIMEOUT_CYCLES 1000  max cycles spent in FILL+DRAIN per command before timeout fault
//  SETTLE_CYCLES  4     valves-off cycles before re-checking level (slosh settle)
//  HYST           2     hysteresis band; re-actuate only if level is off target by more than HYST
//  MAX_LEVEL      1000  overflow cutoff level (used only with WLC_OVERFLOW_GUARD_EN)
// PORTS
//  clk                 in   1        system clock, rising edge
//  reset               in   1        asynchronous, active-high reset
//  start               in   1        command strobe; accepted only in IDLE
//  op                  in   1        1 = fill, 0 = drain; sampled with start
//  target_level        in   LEVEL_W  target level; sampled with start
//  abort               in   1        cancel command / clear fault
//  water_level_sensor  in   LEVEL_W  current level (unsigned)
//  flow_error          in   1        stall flag from flow monitor
//  inlet_valve         out  1        1 = inlet open
//  drain_pump          out  1        1 = pump on
//  monitor_mode        out  1        latched op, fed to monitor mode input
//  busy                out  1        1 in any state other than IDLE and FAULT
//  done                out  1        one-cycle success pulse
//  fault               out  1        sticky fault indication
//  fault_code          out  2        00 none, 01 timeout, 10 flow_error, 11 overflow
// BEHAVIOUR
//  - Reset (async): state = IDLE; all outputs 0; latched op/target and counters cleared.
//    Reset mid-fill or mid-drain closes the valve and stops the pump immediately.
//  - States: IDLE, FILL, DRAIN, SETTLE, DONE, FAULT. All outputs are registered.
//  - IDLE: on start, latch op -> monitor_mode and target, and clear the timeout counter.
//    - Fill with level >= target: go to DONE, no actuation.
//    - Drain with level <= target: go to DONE, no actuation.
//    - Otherwise go to FILL or DRAIN.
//  - FILL: inlet_valve = 1. When level >= target, go to SETTLE.
//  - DRAIN: drain_pump = 1. When level <= target, go to SETTLE.
//  - Timeout counter increments every cycle spent in FILL or DRAIN. It is NOT cleared on
//    SETTLE re-entry. Reaching TIMEOUT_CYCLES -> FAULT, code 01.
//  - SETTLE: both actuators off for SETTLE_CYCLES cycles, then re-check.
//    - Fill: level < target-HYST -> back to FILL; else DONE.
//    - Drain: level > target+HYST -> back to DRAIN; else DONE.
//    - target-HYST saturates at 0; target+HYST saturates at 2^LEVEL_W-1.
//  - DONE: done = 1 for exactly one cycle, then IDLE. Latency from start to done is at
//    least 2 cycles when no actuation is needed.
//  - FAULT: actuators off; fault = 1 and fault_code held; start ignored.
//    abort -> IDLE, clearing fault and fault_code.
//  - Priority when events coincide in one cycle:
//    abort > overflow > flow_error > timeout > level reached.
//  - abort in FILL, DRAIN or SETTLE -> IDLE next cycle with actuators off and no done.
//  - flow_error is honoured only in FILL and DRAIN; it is ignored in IDLE, SETTLE and DONE.
//  - Invariant: inlet_valve & drain_pump is never 1. start while busy is ignored.
// CONFIGURATION
//  WLC_OVERFLOW_GUARD_EN defined:
//   - In any state, level >= MAX_LEVEL forces inlet_valve to 0 combinationally.
//   - If this occurs in FILL or SETTLE with op = fill -> FAULT, code 11.
//  WLC_OVERFLOW_GUARD_EN undefined:
//   - No guard logic; MAX_LEVEL is unused; code 11 is never produced.
// TESTING
//  T1 fill: level 100, start op=1 target 300, level ramps +5/cycle
//     -> inlet_valve 1 until level >= 300, SETTLE 4 cycles, done pulse, busy 0.
//  T2 drain already met: level 50, start op=0 target 80
//     -> no actuation, done pulse 2 cycles after start.
//  T3 timeout: TIMEOUT_CYCLES=20, level frozen at 100, fill to 300
//     -> FAULT code 01 after 20 FILL cycles, valve 0; abort clears fault.
//  T4 flow_error asserted in DRAIN
//     -> next cycle drain_pump 0, fault 1, code 10; start ignored until abort.
//  T5 slosh: fill target 300, level drops to 297 during SETTLE
//     -> re-enters FILL (297 < 298); a drop to 298 instead -> done.
//  T6 reset mid-FILL and start-while-busy
//     -> outputs 0 asynchronously on reset; with WLC_OVERFLOW_GUARD_EN, level 1000 in FILL
//        -> valve 0, code 11.

Source files
------------

// File: rtl/water_level_if.sv
// Command/sensor/actuator bundle between the wash sequencer, level controller and valve/pump drivers.
interface water_level_if #(
    parameter int unsigned LEVEL_W = 10
);
    logic               start;
    logic               op;
    logic [LEVEL_W-1:0] target_level;
    logic               abort;
    logic [LEVEL_W-1:0] water_level_sensor;
    logic               flow_error;
    logic               inlet_valve;
    logic               drain_pump;
    logic               monitor_mode;
    logic               busy;
    logic               done;
    logic               fault;
    logic [1:0]         fault_code;

    modport master (
        output start, op, target_level, abort, water_level_sensor, flow_error,
        input  inlet_valve, drain_pump, monitor_mode, busy, done, fault, fault_code
    );

    modport slave (
        input  start, op, target_level, abort, water_level_sensor, flow_error,
        output inlet_valve, drain_pump, monitor_mode, busy, done, fault, fault_code
    );
endinterface

// File: rtl/water_level_controller.sv
// Drives inlet valve / drain pump to a commanded drum level, then reports done or fault.
// Optional overflow cutoff enabled by defining WLC_OVERFLOW_GUARD_EN.
module water_level_controller #(
`ifdef WLC_OVERFLOW_GUARD_EN
    parameter int unsigned MAX_LEVEL      = 1000,
`endif
    parameter int unsigned LEVEL_W        = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned HYST           = 2
) (
    input  logic          clk,
    input  logic          reset,
    water_level_if.slave  bus
);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned STL_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned LW1   = LEVEL_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_DRAIN, S_SETTLE, S_DONE, S_FAULT
    } state_t;

    state_t             r_state, w_next;
    logic               r_op, w_op_n;
    logic [LEVEL_W-1:0] r_target, w_target_n;
    logic [TMO_W-1:0]   r_tmo, w_tmo_n;
    logic [STL_W-1:0]   r_settle, w_settle_n;
    logic [1:0]         r_code, w_code_n;
    logic               r_inlet, r_pump, r_busy, r_done, r_fault;

    logic [LEVEL_W-1:0] w_level, w_lo, w_hi;
    logic [LEVEL_W:0]   w_hi_sum;
    logic               w_ovf, w_reached;

    assign w_level = bus.water_level_sensor;

`ifdef WLC_OVERFLOW_GUARD_EN
    assign w_ovf = (w_level >= LEVEL_W'(MAX_LEVEL));
`else
    assign w_ovf = 1'b0;
`endif

    // Hysteresis window around the latched target, saturating at the sensor range.
    assign w_hi_sum  = {1'b0, r_target} + LW1'(HYST);
    assign w_hi      = w_hi_sum[LEVEL_W] ? '1 : w_hi_sum[LEVEL_W-1:0];
    assign w_lo      = (r_target > LEVEL_W'(HYST)) ? (r_target - LEVEL_W'(HYST)) : '0;
    assign w_reached = r_op ? (w_level >= r_target) : (w_level <= r_target);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= 1'b0;
            r_target <= '0;
            r_tmo    <= '0;
            r_settle <= '0;
            r_code   <= 2'b00;
            r_inlet  <= 1'b0;
            r_pump   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_op     <= w_op_n;
            r_target <= w_target_n;
            r_tmo    <= w_tmo_n;
            r_settle <= w_settle_n;
            r_code   <= w_code_n;
            r_inlet  <= (w_next == S_FILL);
            r_pump   <= (w_next == S_DRAIN);
            r_busy   <= (w_next inside {S_FILL, S_DRAIN, S_SETTLE, S_DONE});
            r_done   <= (r_state == S_DONE);
            r_fault  <= (w_next == S_FAULT);
        end
    end

    // Next state; within a cycle abort > overflow > flow_error > timeout > level reached.
    always_comb begin
        w_next     = r_state;
        w_op_n     = r_op;
        w_target_n = r_target;
        w_tmo_n    = r_tmo;
        w_settle_n = r_settle;
        w_code_n   = r_code;
        case (r_state)
            S_IDLE: begin
                w_code_n = 2'b00;
                if (bus.start) begin
                    w_op_n     = bus.op;
                    w_target_n = bus.target_level;
                    w_tmo_n    = '0;
                    if (bus.op ? (w_level >= bus.target_level) : (w_level <= bus.target_level))
                        w_next = S_DONE;
                    else
                        w_next = bus.op ? S_FILL : S_DRAIN;
                end
            end
            S_FILL, S_DRAIN: begin
                w_tmo_n = r_tmo + TMO_W'(1);
                if (bus.abort) begin
                    w_next = S_IDLE;
                end else if ((r_state == S_FILL) && w_ovf) begin
                    w_next   = S_FAULT;
                    w_code_n = 2'b11;
                end else if (bus.flow_error) begin
                    w_next   = S_FAULT;
                    w_code_n = 2'b10;
                end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    w_next   = S_FAULT;
                    w_code_n = 2'b01;
                end else if (w_reached) begin
                    w_next     = S_SETTLE;
                    w_settle_n = '0;
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    w_next = S_IDLE;
                end else if (r_op && w_ovf) begin
                    w_next   = S_FAULT;
                    w_code_n = 2'b11;
                end else if (r_settle == STL_W'(SETTLE_CYCLES - 1)) begin
                    if (r_op ? (w_level < w_lo) : (w_level > w_hi))
                        w_next = r_op ? S_FILL : S_DRAIN;
                    else
                        w_next = S_DONE;
                end else begin
                    w_settle_n = r_settle + STL_W'(1);
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_FAULT: begin
                if (bus.abort) begin
                    w_next   = S_IDLE;
                    w_code_n = 2'b00;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.inlet_valve  = r_inlet & ~w_ovf;
    assign bus.drain_pump   = r_pump;
    assign bus.monitor_mode = r_op;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.fault        = r_fault;
    assign bus.fault_code   = r_code;
endmodule
